// File: rtl/axi_stream_extract_header.sv
// rtl/axi_stream_extract_header.sv - split a leading H-byte header off an AXI-Stream packet
// Header goes out LSB-aligned on its own channel; payload is re-packed MSB-aligned.

module axi_stream_extract_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic [BYTE_CNT_WD-1:0]  byte_extract_cnt,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  output logic                    valid_hdr,
  output logic [DATA_WD-1:0]      data_hdr,
  output logic [DATA_BYTE_WD-1:0] keep_hdr,
  input  logic                    ready_hdr,
  output logic                    err_short
);

  localparam int W = DATA_BYTE_WD;
  localparam logic [W-1:0] ONES = '1;

  typedef enum logic [1:0] {
    S_HDR   = 2'd0,
    S_BODY  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t                 state;
  logic                   run;
  logic [DATA_WD-1:0]     residue;
  logic [BYTE_CNT_WD:0]   res_bytes;
  logic [W-1:0]           flush_keep;

  logic [DATA_WD-1:0]     data_m;
  logic                   out_free;
  logic                   hdr_free;
  logic                   accept;
  int                     h;
  int                     k;
  int                     r;

  // Bytes beyond keep are zeroed so every shifted result is already padded.
  always_comb begin
    data_m = '0;
    for (int i = 0; i < W; i++) begin
      data_m[8*i +: 8] = data_in[8*i +: 8] & {8{keep_in[i]}};
    end
  end

  always_comb begin
    h = int'(byte_extract_cnt) + 1;
    k = $countones(keep_in);
    r = int'(res_bytes);
  end

  assign out_free = !valid_out || ready_out;
  assign hdr_free = !valid_hdr || ready_hdr;
  assign accept   = valid_in && ready_in;

  // run keeps ready_in low while reset is asserted and for the first edge after.
  always_comb begin
    ready_in = 1'b0;
    case (state)
      S_HDR:   ready_in = run && hdr_free && out_free;
      S_BODY:  ready_in = run && out_free;
      default: ready_in = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_HDR;
      run        <= 1'b0;
      residue    <= '0;
      res_bytes  <= '0;
      flush_keep <= '0;
      valid_out  <= 1'b0;
      data_out   <= '0;
      keep_out   <= '0;
      last_out   <= 1'b0;
      valid_hdr  <= 1'b0;
      data_hdr   <= '0;
      keep_hdr   <= '0;
      err_short  <= 1'b0;
    end else begin
      run       <= 1'b1;
      err_short <= 1'b0;
      if (valid_out && ready_out) valid_out <= 1'b0;
      if (valid_hdr && ready_hdr) valid_hdr <= 1'b0;

      case (state)
        S_HDR: begin
          if (accept) begin
            residue   <= data_m;
            res_bytes <= (BYTE_CNT_WD+1)'(W - h);
            valid_hdr <= 1'b1;
            if (last_in && k < h) begin
              data_hdr  <= data_m >> (8 * (W - k));
              keep_hdr  <= ONES >> (W - k);
              err_short <= 1'b1;
            end else begin
              data_hdr <= data_m >> (8 * (W - h));
              keep_hdr <= ONES >> (W - h);
            end
            if (!last_in) begin
              state <= S_BODY;
            end else if (k > h) begin
              valid_out <= 1'b1;
              data_out  <= data_m << (8 * h);
              keep_out  <= ~(ONES >> (k - h));
              last_out  <= 1'b1;
            end
          end
        end

        S_BODY: begin
          if (accept) begin
            valid_out <= 1'b1;
            residue   <= data_m;
            if (r == 0) begin
              data_out <= data_m;
              keep_out <= keep_in;
              last_out <= last_in;
              if (last_in) state <= S_HDR;
            end else if (!last_in) begin
              data_out <= (residue << (8 * (W - r))) | (data_m >> (8 * r));
              keep_out <= ONES;
              last_out <= 1'b0;
            end else if (r + k <= W) begin
              data_out <= (residue << (8 * (W - r))) | (data_m >> (8 * r));
              keep_out <= ~(ONES >> (r + k));
              last_out <= 1'b1;
              state    <= S_HDR;
            end else begin
              // Residue plus last beat overflows one beat: finish in S_FLUSH.
              data_out   <= (residue << (8 * (W - r))) | (data_m >> (8 * r));
              keep_out   <= ONES;
              last_out   <= 1'b0;
              flush_keep <= ~(ONES >> (r + k - W));
              state      <= S_FLUSH;
            end
          end
        end

        S_FLUSH: begin
          if (out_free) begin
            valid_out <= 1'b1;
            data_out  <= residue << (8 * (W - r));
            keep_out  <= flush_keep;
            last_out  <= 1'b1;
            state     <= S_HDR;
          end
        end

        default: state <= S_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// tb/tb_axi_stream_extract_header.sv - directed bench for axi_stream_extract_header
// Inputs change 1 time unit after posedge; outputs are observed on the negedge.

module tb_axi_stream_extract_header;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        last_in;
  logic        ready_in;
  logic [1:0]  byte_extract_cnt;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out;
  logic        valid_hdr;
  logic [31:0] data_hdr;
  logic [3:0]  keep_hdr;
  logic        ready_hdr;
  logic        err_short;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t out_q[$];
  beat_t hdr_q[$];
  int    err_cnt;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  axi_stream_extract_header #(.DATA_WD(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in), .byte_extract_cnt(byte_extract_cnt),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out),
    .valid_hdr(valid_hdr), .data_hdr(data_hdr), .keep_hdr(keep_hdr), .ready_hdr(ready_hdr),
    .err_short(err_short)
  );

  // Handshakes seen at the negedge complete on the following posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_out && ready_out) out_q.push_back({data_out, keep_out, last_out});
      if (valid_hdr && ready_hdr) hdr_q.push_back({data_hdr, keep_hdr, 1'b0});
      if (err_short) err_cnt++;
    end
  end

  task automatic clear_q;
    out_q.delete();
    hdr_q.delete();
    err_cnt = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n;
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
    n = 0;
    @(negedge clk);
    while (!ready_in && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (!ready_in) begin
      errors++;
      $display("FAIL send_timeout data %h ready_in %b required 1", d, ready_in);
    end
    @(posedge clk); #1;
    valid_in = 1'b0; last_in = 1'b0;
  endtask

  task automatic drain;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({valid_out, valid_hdr, last_out, err_short, ready_in} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags vo,vh,lo,err,rdy got %b required 00000",
               {valid_out, valid_hdr, last_out, err_short, ready_in});
    end
    checks++;
    if ({data_out, keep_out, data_hdr, keep_hdr} !== 72'h0) begin
      errors++;
      $display("FAIL reset_regs got %h %h %h %h required all 0", data_out, keep_out, data_hdr, keep_hdr);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready_in !== 1'b1) begin
      errors++;
      $display("FAIL reset_release ready_in %b required 1", ready_in);
    end
  endtask

  task automatic test_realign;
    beat_t eh[$];
    beat_t eo[$];
    clear_q();
    byte_extract_cnt = 2'd1;
    send(32'hA1A2A3A4, 4'hF, 1'b0);
    send(32'hB1B2B3B4, 4'hF, 1'b0);
    send(32'hC1C2C3C4, 4'hC, 1'b1);
    drain();
    eh.push_back({32'h0000A1A2, 4'h3, 1'b0});
    eo.push_back({32'hA3A4B1B2, 4'hF, 1'b0});
    eo.push_back({32'hB3B4C1C2, 4'hF, 1'b1});
    checks++;
    if (hdr_q.size() != eh.size() || out_q.size() != eo.size() || err_cnt != 0) begin
      errors++;
      $display("FAIL realign_counts hdr %0d out %0d err %0d required %0d %0d 0",
               hdr_q.size(), out_q.size(), err_cnt, eh.size(), eo.size());
    end
    for (int i = 0; i < eh.size(); i++) begin
      checks++;
      if (i >= hdr_q.size() || hdr_q[i] !== eh[i]) begin
        errors++;
        $display("FAIL realign_hdr[%0d] got %h required %h", i, (i < hdr_q.size()) ? hdr_q[i] : '0, eh[i]);
      end
    end
    for (int i = 0; i < eo.size(); i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== eo[i]) begin
        errors++;
        $display("FAIL realign_out[%0d] got %h required %h", i, (i < out_q.size()) ? out_q[i] : '0, eo[i]);
      end
    end
  endtask

  task automatic test_flush;
    beat_t eh[$];
    beat_t eo[$];
    clear_q();
    byte_extract_cnt = 2'd0;
    send(32'hA1A2A3A4, 4'hF, 1'b0);
    send(32'hB1B2B3B4, 4'hF, 1'b1);
    checks++;
    if (ready_in !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready_in got %b required 0", ready_in);
    end
    drain();
    eh.push_back({32'h000000A1, 4'h1, 1'b0});
    eo.push_back({32'hA2A3A4B1, 4'hF, 1'b0});
    eo.push_back({32'hB2B3B400, 4'hE, 1'b1});
    checks++;
    if (hdr_q.size() != eh.size() || out_q.size() != eo.size() || err_cnt != 0) begin
      errors++;
      $display("FAIL flush_counts hdr %0d out %0d err %0d required %0d %0d 0",
               hdr_q.size(), out_q.size(), err_cnt, eh.size(), eo.size());
    end
    for (int i = 0; i < eh.size(); i++) begin
      checks++;
      if (i >= hdr_q.size() || hdr_q[i] !== eh[i]) begin
        errors++;
        $display("FAIL flush_hdr[%0d] got %h required %h", i, (i < hdr_q.size()) ? hdr_q[i] : '0, eh[i]);
      end
    end
    for (int i = 0; i < eo.size(); i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== eo[i]) begin
        errors++;
        $display("FAIL flush_out[%0d] got %h required %h", i, (i < out_q.size()) ? out_q[i] : '0, eo[i]);
      end
    end
  endtask

  task automatic test_passthrough;
    beat_t eh[$];
    beat_t eo[$];
    clear_q();
    byte_extract_cnt = 2'd3;
    send(32'hA1A2A3A4, 4'hF, 1'b0);
    send(32'hB1B2B3B4, 4'hF, 1'b0);
    send(32'hC1000000, 4'h8, 1'b1);
    drain();
    eh.push_back({32'hA1A2A3A4, 4'hF, 1'b0});
    eo.push_back({32'hB1B2B3B4, 4'hF, 1'b0});
    eo.push_back({32'hC1000000, 4'h8, 1'b1});
    checks++;
    if (hdr_q.size() != eh.size() || out_q.size() != eo.size() || err_cnt != 0) begin
      errors++;
      $display("FAIL pass_counts hdr %0d out %0d err %0d required %0d %0d 0",
               hdr_q.size(), out_q.size(), err_cnt, eh.size(), eo.size());
    end
    for (int i = 0; i < eh.size(); i++) begin
      checks++;
      if (i >= hdr_q.size() || hdr_q[i] !== eh[i]) begin
        errors++;
        $display("FAIL pass_hdr[%0d] got %h required %h", i, (i < hdr_q.size()) ? hdr_q[i] : '0, eh[i]);
      end
    end
    for (int i = 0; i < eo.size(); i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== eo[i]) begin
        errors++;
        $display("FAIL pass_out[%0d] got %h required %h", i, (i < out_q.size()) ? out_q[i] : '0, eo[i]);
      end
    end
  endtask

  task automatic test_single_beat;
    beat_t eh[$];
    beat_t eo[$];
    clear_q();
    byte_extract_cnt = 2'd2;
    send(32'hA1A2A3A4, 4'hF, 1'b1);
    send(32'hB1B2B3B4, 4'hE, 1'b1);
    byte_extract_cnt = 2'd3;
    send(32'hC1C2C3C4, 4'hC, 1'b1);
    drain();
    eh.push_back({32'h00A1A2A3, 4'h7, 1'b0});
    eh.push_back({32'h00B1B2B3, 4'h7, 1'b0});
    eh.push_back({32'h0000C1C2, 4'h3, 1'b0});
    eo.push_back({32'hA4000000, 4'h8, 1'b1});
    checks++;
    if (hdr_q.size() != eh.size() || out_q.size() != eo.size()) begin
      errors++;
      $display("FAIL single_counts hdr %0d out %0d required %0d %0d",
               hdr_q.size(), out_q.size(), eh.size(), eo.size());
    end
    checks++;
    if (err_cnt != 1) begin
      errors++;
      $display("FAIL single_err_short pulses %0d required 1", err_cnt);
    end
    for (int i = 0; i < eh.size(); i++) begin
      checks++;
      if (i >= hdr_q.size() || hdr_q[i] !== eh[i]) begin
        errors++;
        $display("FAIL single_hdr[%0d] got %h required %h", i, (i < hdr_q.size()) ? hdr_q[i] : '0, eh[i]);
      end
    end
    for (int i = 0; i < eo.size(); i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== eo[i]) begin
        errors++;
        $display("FAIL single_out[%0d] got %h required %h", i, (i < out_q.size()) ? out_q[i] : '0, eo[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    beat_t eh[$];
    beat_t eo[$];
    time   t0;
    time   t1;
    clear_q();
    t0 = $time;
    byte_extract_cnt = 2'd1;
    send(32'hA1A2A3A4, 4'hF, 1'b0);
    send(32'hB1B2B3B4, 4'hF, 1'b0);
    send(32'hC1C2C3C4, 4'hC, 1'b1);
    byte_extract_cnt = 2'd0;
    send(32'hD1D2D3D4, 4'hF, 1'b0);
    send(32'hE1E2E3E4, 4'hF, 1'b1);
    t1 = $time;
    drain();
    checks++;
    if (t1 - t0 != 50) begin
      errors++;
      $display("FAIL b2b_throughput took %0t required 50", t1 - t0);
    end
    eh.push_back({32'h0000A1A2, 4'h3, 1'b0});
    eh.push_back({32'h000000D1, 4'h1, 1'b0});
    eo.push_back({32'hA3A4B1B2, 4'hF, 1'b0});
    eo.push_back({32'hB3B4C1C2, 4'hF, 1'b1});
    eo.push_back({32'hD2D3D4E1, 4'hF, 1'b0});
    eo.push_back({32'hE2E3E400, 4'hE, 1'b1});
    checks++;
    if (hdr_q.size() != eh.size() || out_q.size() != eo.size()) begin
      errors++;
      $display("FAIL b2b_counts hdr %0d out %0d required %0d %0d",
               hdr_q.size(), out_q.size(), eh.size(), eo.size());
    end
    for (int i = 0; i < eh.size(); i++) begin
      checks++;
      if (i >= hdr_q.size() || hdr_q[i] !== eh[i]) begin
        errors++;
        $display("FAIL b2b_hdr[%0d] got %h required %h", i, (i < hdr_q.size()) ? hdr_q[i] : '0, eh[i]);
      end
    end
    for (int i = 0; i < eo.size(); i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== eo[i]) begin
        errors++;
        $display("FAIL b2b_out[%0d] got %h required %h", i, (i < out_q.size()) ? out_q[i] : '0, eo[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    beat_t eh[$];
    beat_t eo[$];
    bit    done;
    beat_t po;
    beat_t ph;
    bit    pvo, pro, pvh, prh;
    int    go, gh;
    clear_q();
    done = 0;
    byte_extract_cnt = 2'd1;
    fork
      begin
        send(32'hA1A2A3A4, 4'hF, 1'b0);
        send(32'hB1B2B3B4, 4'hF, 1'b0);
        send(32'hC1C2C3C4, 4'hC, 1'b1);
      end
      begin
        go = 0; gh = 0;
        for (int n = 0; n < 600 && !(out_q.size() >= 2 && hdr_q.size() >= 1); n++) begin
          @(posedge clk); #1;
          if (go == 0) begin ready_out = 1'b1; go = $urandom_range(1, 10); end
          else begin ready_out = 1'b0; go--; end
          if (gh == 0) begin ready_hdr = 1'b1; gh = $urandom_range(1, 10); end
          else begin ready_hdr = 1'b0; gh--; end
        end
        done = 1;
      end
      begin
        pvo = 0; pro = 0; pvh = 0; prh = 0; po = '0; ph = '0;
        @(negedge clk);
        while (!done) begin
          if (pvo && !pro) begin
            checks++;
            if (valid_out !== 1'b1 || {data_out, keep_out, last_out} !== po) begin
              errors++;
              $display("FAIL bp_out_stable got %b %h required 1 %h", valid_out, {data_out, keep_out, last_out}, po);
            end
          end
          if (pvh && !prh) begin
            checks++;
            if (valid_hdr !== 1'b1 || {data_hdr, keep_hdr, 1'b0} !== ph) begin
              errors++;
              $display("FAIL bp_hdr_stable got %b %h required 1 %h", valid_hdr, {data_hdr, keep_hdr, 1'b0}, ph);
            end
          end
          if (valid_out && !ready_out) begin
            checks++;
            if (ready_in !== 1'b0) begin
              errors++;
              $display("FAIL bp_ready_in got %b required 0", ready_in);
            end
          end
          pvo = valid_out; pro = ready_out; po = {data_out, keep_out, last_out};
          pvh = valid_hdr; prh = ready_hdr; ph = {data_hdr, keep_hdr, 1'b0};
          @(negedge clk);
        end
      end
    join
    @(posedge clk); #1;
    ready_out = 1'b1; ready_hdr = 1'b1;
    drain();
    eh.push_back({32'h0000A1A2, 4'h3, 1'b0});
    eo.push_back({32'hA3A4B1B2, 4'hF, 1'b0});
    eo.push_back({32'hB3B4C1C2, 4'hF, 1'b1});
    checks++;
    if (hdr_q.size() != eh.size() || out_q.size() != eo.size()) begin
      errors++;
      $display("FAIL bp_counts hdr %0d out %0d required %0d %0d",
               hdr_q.size(), out_q.size(), eh.size(), eo.size());
    end
    for (int i = 0; i < eh.size(); i++) begin
      checks++;
      if (i >= hdr_q.size() || hdr_q[i] !== eh[i]) begin
        errors++;
        $display("FAIL bp_hdr[%0d] got %h required %h", i, (i < hdr_q.size()) ? hdr_q[i] : '0, eh[i]);
      end
    end
    for (int i = 0; i < eo.size(); i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== eo[i]) begin
        errors++;
        $display("FAIL bp_out[%0d] got %h required %h", i, (i < out_q.size()) ? out_q[i] : '0, eo[i]);
      end
    end
  endtask

  task automatic test_reset_mid_packet;
    beat_t eh[$];
    beat_t eo[$];
    clear_q();
    ready_out = 1'b0; ready_hdr = 1'b0;
    byte_extract_cnt = 2'd1;
    send(32'h11121314, 4'hF, 1'b0);
    send(32'h21222324, 4'hF, 1'b0);
    checks++;
    if (valid_hdr !== 1'b1 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre vh %b vo %b required 1 1", valid_hdr, valid_out);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({valid_out, valid_hdr, last_out, err_short, ready_in} !== 5'b0 ||
        {data_out, keep_out, data_hdr, keep_hdr} !== 72'h0) begin
      errors++;
      $display("FAIL midrst_outputs flags %b regs %h required all 0",
               {valid_out, valid_hdr, last_out, err_short, ready_in},
               {data_out, keep_out, data_hdr, keep_hdr});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_out = 1'b1; ready_hdr = 1'b1;
    @(posedge clk); #1;
    clear_q();
    send(32'hA1A2A3A4, 4'hF, 1'b0);
    send(32'hB1B2B3B4, 4'hF, 1'b0);
    send(32'hC1C2C3C4, 4'hC, 1'b1);
    drain();
    eh.push_back({32'h0000A1A2, 4'h3, 1'b0});
    eo.push_back({32'hA3A4B1B2, 4'hF, 1'b0});
    eo.push_back({32'hB3B4C1C2, 4'hF, 1'b1});
    checks++;
    if (hdr_q.size() != eh.size() || out_q.size() != eo.size()) begin
      errors++;
      $display("FAIL midrst_counts hdr %0d out %0d required %0d %0d",
               hdr_q.size(), out_q.size(), eh.size(), eo.size());
    end
    for (int i = 0; i < eh.size(); i++) begin
      checks++;
      if (i >= hdr_q.size() || hdr_q[i] !== eh[i]) begin
        errors++;
        $display("FAIL midrst_hdr[%0d] got %h required %h", i, (i < hdr_q.size()) ? hdr_q[i] : '0, eh[i]);
      end
    end
    for (int i = 0; i < eo.size(); i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== eo[i]) begin
        errors++;
        $display("FAIL midrst_out[%0d] got %h required %h", i, (i < out_q.size()) ? out_q[i] : '0, eo[i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    byte_extract_cnt = '0;
    ready_out = 1'b1; ready_hdr = 1'b1;
    err_cnt = 0;
    test_reset();
    test_realign();
    test_flush();
    test_passthrough();
    test_single_beat();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
